// File: rtl/decode_hazard_scoreboard.sv
// Purpose : per-register count of in-flight writes; raises stall on RAW source hazards and when the destination counter is saturated.
// Latency : stall/issue_fire are combinational from the current inputs and the registered counts; count updates are visible one cycle after the edge.
// Backpressure: stall holds decode, and the instruction is not issued that cycle. Retire and cancel are never back-pressured.
//
// Ports:
//   clk, rst                         clock; synchronous active-high reset
//   issue_valid/writes_rd/rd         decode-side instruction and its destination
//   rs1_used/rs1, rs2_used/rs2       source operands checked for pending writes
//   stall, issue_fire                hold decode / instruction accepted this cycle
//   retire_valid/retire_rd           writeback commit, decrements the counter
//   cancel_valid/cancel_rd           squashed in-flight write, decrements the counter
//   flush_all                        clears all counters (error is kept)
//   busy_mask                        registered, bit i = (count[i] != 0)
//   error                            sticky counter-underflow flag, cleared only by rst
module decode_hazard_scoreboard #(
    parameter int REGISTER_DEPTH = 32,
    parameter int CNT_WIDTH      = 2,
    localparam int AW            = $clog2(REGISTER_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic                      issue_writes_rd,
    input  logic [AW-1:0]             issue_rd,
    input  logic                      rs1_used,
    input  logic [AW-1:0]             rs1,
    input  logic                      rs2_used,
    input  logic [AW-1:0]             rs2,
    output logic                      stall,
    output logic                      issue_fire,
    input  logic                      retire_valid,
    input  logic [AW-1:0]             retire_rd,
    input  logic                      cancel_valid,
    input  logic [AW-1:0]             cancel_rd,
    input  logic                      flush_all,
    output logic [REGISTER_DEPTH-1:0] busy_mask,
    output logic                      error
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH:0]   ONE_X   = {{CNT_WIDTH{1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0]      count_q [REGISTER_DEPTH];
    logic [CNT_WIDTH-1:0]      count_d [REGISTER_DEPTH];
    logic [REGISTER_DEPTH-1:0] busy_mask_q, busy_mask_d;
    logic                      error_q, error_d;

    logic hz1, hz2, hzs;

    // Hazard detection. Register 0 is never busy, so its address is masked out.
    always_comb begin
        hz1        = rs1_used && (rs1 != '0) && (count_q[rs1] != '0);
        hz2        = rs2_used && (rs2 != '0) && (count_q[rs2] != '0);
        hzs        = issue_writes_rd && (issue_rd != '0) && (count_q[issue_rd] == CNT_MAX);
        stall      = issue_valid && (hz1 || hz2 || hzs);
        issue_fire = issue_valid && !stall;
    end

    // Counter update. The sum is formed one bit wider, so a net decrement
    // below zero shows up as the top bit. The increment can never carry into
    // that bit because hzs blocks issue at CNT_MAX.
    logic                 inc, dec_w, dec_c, underflow;
    logic [CNT_WIDTH:0]   nxt;

    always_comb begin
        count_d    = count_q;
        error_d    = error_q;
        underflow  = 1'b0;
        inc        = 1'b0;
        dec_w      = 1'b0;
        dec_c      = 1'b0;
        nxt        = '0;
        count_d[0] = '0;
        for (int r = 1; r < REGISTER_DEPTH; r++) begin
            inc   = issue_fire && issue_writes_rd && (issue_rd == AW'(r));
            dec_w = retire_valid && (retire_rd == AW'(r));
            dec_c = cancel_valid && (cancel_rd == AW'(r));
            nxt   = {1'b0, count_q[r]};
            if (inc)   nxt = nxt + ONE_X;
            if (dec_w) nxt = nxt - ONE_X;
            if (dec_c) nxt = nxt - ONE_X;
            if (nxt[CNT_WIDTH]) begin
                count_d[r] = '0;
                underflow  = 1'b1;
            end else begin
                count_d[r] = nxt[CNT_WIDTH-1:0];
            end
        end
        if (underflow) error_d = 1'b1;

        // A flush overrides every event this cycle, including one that would underflow.
        if (flush_all) begin
            for (int r = 0; r < REGISTER_DEPTH; r++) count_d[r] = '0;
            error_d = error_q;
        end

        for (int r = 0; r < REGISTER_DEPTH; r++) busy_mask_d[r] = (count_d[r] != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REGISTER_DEPTH; r++) count_q[r] <= '0;
            busy_mask_q <= '0;
            error_q     <= 1'b0;
        end else begin
            count_q     <= count_d;
            busy_mask_q <= busy_mask_d;
            error_q     <= error_d;
        end
    end

    assign busy_mask = busy_mask_q;
    assign error     = error_q;

endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// Directed test for decode_hazard_scoreboard.
// Inputs are driven 1 time unit after a rising edge, and outputs are sampled 1 time unit later, before the next edge.
module tb_decode_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_writes_rd, rs1_used, rs2_used;
    logic [4:0]  issue_rd, rs1, rs2, retire_rd, cancel_rd;
    logic        retire_valid, cancel_valid, flush_all;
    logic        stall, issue_fire, error;
    logic [31:0] busy_mask;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_hazard_scoreboard #(.REGISTER_DEPTH(32), .CNT_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_writes_rd(issue_writes_rd), .issue_rd(issue_rd),
        .rs1_used(rs1_used), .rs1(rs1), .rs2_used(rs2_used), .rs2(rs2),
        .stall(stall), .issue_fire(issue_fire),
        .retire_valid(retire_valid), .retire_rd(retire_rd),
        .cancel_valid(cancel_valid), .cancel_rd(cancel_rd),
        .flush_all(flush_all), .busy_mask(busy_mask), .error(error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_writes_rd = 0; issue_rd = 0;
        rs1_used = 0; rs1 = 0; rs2_used = 0; rs2 = 0;
        retire_valid = 0; retire_rd = 0; cancel_valid = 0; cancel_rd = 0;
        flush_all = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue_wr(input logic [4:0] rd);
        issue_valid = 1; issue_writes_rd = 1; issue_rd = rd;
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;

        // Reset state
        settle();
        chk("rst_busy", busy_mask, 32'h0);
        chk("rst_error", {31'h0, error}, 32'h0);
        chk("idle_stall", {31'h0, stall}, 32'h0);
        chk("idle_fire", {31'h0, issue_fire}, 32'h0);
        issue_valid = 1; rs1_used = 1; rs1 = 5;
        settle();
        chk("rst_rs1_stall", {31'h0, stall}, 32'h0);
        chk("rst_rs1_fire", {31'h0, issue_fire}, 32'h1);
        tick();

        // RAW on r5: the retire in cycle 3 releases the stall in cycle 4
        idle(); issue_wr(5);
        settle();
        chk("c0_fire", {31'h0, issue_fire}, 32'h1);
        tick();
        idle(); issue_valid = 1; rs1_used = 1; rs1 = 5;
        settle();
        chk("c1_stall", {31'h0, stall}, 32'h1);
        chk("c1_fire", {31'h0, issue_fire}, 32'h0);
        chk("c1_busy5", {31'h0, busy_mask[5]}, 32'h1);
        tick();
        chk("c2_stall", {31'h0, stall}, 32'h1);
        tick();
        retire_valid = 1; retire_rd = 5;
        settle();
        chk("c3_stall", {31'h0, stall}, 32'h1);
        tick();
        retire_valid = 0;
        settle();
        chk("c4_stall", {31'h0, stall}, 32'h0);
        chk("c4_fire", {31'h0, issue_fire}, 32'h1);
        chk("c4_busy", busy_mask, 32'h0);

        // Saturation of r7
        for (int i = 0; i < 3; i++) begin
            idle(); issue_wr(7);
            settle();
            chk("sat_fire", {31'h0, issue_fire}, 32'h1);
            tick();
        end
        idle(); issue_wr(7);
        settle();
        chk("sat4_stall", {31'h0, stall}, 32'h1);
        retire_valid = 1; retire_rd = 7;
        settle();
        chk("sat4_retire_stall", {31'h0, stall}, 32'h1);
        tick();
        retire_valid = 0;
        settle();
        chk("sat_after_retire_fire", {31'h0, issue_fire}, 32'h1);
        tick();
        settle();
        chk("sat_back_to_max", {31'h0, stall}, 32'h1);
        idle(); retire_valid = 1; retire_rd = 7;
        tick(); tick(); tick();
        idle();
        settle();
        chk("sat_drained", busy_mask, 32'h0);
        chk("sat_no_err", {31'h0, error}, 32'h0);

        // Issue and retire of r9 in the same cycle, then retire plus cancel
        issue_wr(9);
        tick();
        idle(); issue_wr(9); retire_valid = 1; retire_rd = 9;
        settle();
        chk("r9_fire", {31'h0, issue_fire}, 32'h1);
        tick();
        idle();
        settle();
        chk("r9_busy_still", busy_mask, 32'h200);
        chk("r9_no_err", {31'h0, error}, 32'h0);
        retire_valid = 1; retire_rd = 9; cancel_valid = 1; cancel_rd = 9;
        tick();
        idle();
        settle();
        chk("r9_busy_zero", busy_mask, 32'h0);
        chk("r9_underflow_err", {31'h0, error}, 32'h1);

        // A reset during operation clears the sticky error
        issue_wr(12); rst = 1;
        tick();
        rst = 0; idle();
        settle();
        chk("midrst_err", {31'h0, error}, 32'h0);
        chk("midrst_busy", busy_mask, 32'h0);

        // Register 0 is never tracked
        issue_wr(0); rs1_used = 1; rs2_used = 1;
        settle();
        chk("r0_stall", {31'h0, stall}, 32'h0);
        chk("r0_fire", {31'h0, issue_fire}, 32'h1);
        tick();
        idle(); retire_valid = 1; retire_rd = 0; cancel_valid = 1; cancel_rd = 0;
        tick();
        idle();
        settle();
        chk("r0_busy", busy_mask, 32'h0);
        chk("r0_err", {31'h0, error}, 32'h0);

        // Flush clears the counters and keeps error
        issue_wr(3); tick();
        issue_wr(4); tick();
        issue_wr(6); tick();
        idle(); retire_valid = 1; retire_rd = 10;   // underflow from zero sets error
        tick();
        idle();
        settle();
        chk("pre_flush_busy", busy_mask, 32'h58);
        chk("pre_flush_err", {31'h0, error}, 32'h1);
        flush_all = 1; issue_wr(8);
        settle();
        chk("flush_fire", {31'h0, issue_fire}, 32'h1);
        tick();
        idle(); issue_valid = 1; rs1_used = 1; rs1 = 3;
        settle();
        chk("flush_busy", busy_mask, 32'h0);
        chk("flush_err", {31'h0, error}, 32'h1);
        chk("flush_rs1_stall", {31'h0, stall}, 32'h0);
        tick();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_hazard_scoreboard.md
# decode_hazard_scoreboard

Per-register in-flight write tracker and stall generator for the decode stage. It counts, for every architectural register, how many issued instructions still have a pending write to it. It stalls decode when a source operand, or the destination counter, is not ready. It sits between decode (issue side) and execute/writeback (retire and cancel side), and its stall output gates the fetch-to-decode handshake.

## Interface
Parameters:
- REGISTER_DEPTH, 32, number of architectural registers; register 0 is hardwired zero and never tracked.
- CNT_WIDTH, 2, width of each per-register pending counter; max count = 2^CNT_WIDTH-1.

Ports (AW = $clog2(REGISTER_DEPTH)):
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- issue_valid  in  1  decode holds a valid instruction this cycle.
- issue_writes_rd  in  1  instruction writes rd.
- issue_rd  in  AW  destination register.
- rs1_used  in  1  instruction reads rs1.
- rs1  in  AW  source 1 address.
- rs2_used  in  1  instruction reads rs2.
- rs2  in  AW  source 2 address.
- stall  out  1  decode must hold; instruction is not issued this cycle.
- issue_fire  out  1  issue_valid && !stall; the instruction is accepted.
- retire_valid  in  1  writeback commits a register write this cycle.
- retire_rd  in  AW  register written.
- cancel_valid  in  1  a squashed in-flight instruction that would have written cancel_rd is dropped.
- cancel_rd  in  AW  destination of squashed instruction.
- flush_all  in  1  pipeline fully drained/flushed; clear all counters.
- busy_mask  out  REGISTER_DEPTH  bit i = (count[i] != 0), registered.
- error  out  1  sticky underflow flag.

## Operation
- State: count[i] for i = 1..REGISTER_DEPTH-1, each CNT_WIDTH bits; count[0] is constant 0. Plus the error flag.
- Source hazard conditions:
  - hz1 = rs1_used && rs1 != 0 && count[rs1] != 0.
  - hz2 = rs2_used && rs2 != 0 && count[rs2] != 0.
- Saturation hazard: hzs = issue_writes_rd && issue_rd != 0 && count[issue_rd] == max.
- stall = issue_valid && (hz1 || hz2 || hzs). stall is 0 when issue_valid is 0.
- Per-register next-state update for register r != 0:
  - inc = issue_fire && issue_writes_rd && issue_rd == r.
  - dec_w = retire_valid && retire_rd == r.
  - dec_c = cancel_valid && cancel_rd == r.
  - count[r] next = count[r] + inc - dec_w - dec_c, computed in CNT_WIDTH+1 signed width.
- Underflow: if the result is < 0, count[r] next = 0 and error is set to 1.
- Overflow is impossible, because hzs blocks the increment at max.
- All events on r = 0 are ignored.
- retire and cancel targeting the same register in the same cycle both apply (net -2).
- flush_all has priority over all update events: every count goes to 0. error is unchanged. Any issue_fire in the same cycle is discarded.
- error clears only on rst.

## Timing
- Reset: all count = 0, busy_mask = 0, error = 0. stall and issue_fire are combinational, so they are 0 when issue_valid = 0.
- stall and issue_fire are combinational from current inputs and registered counts. They have zero latency within the cycle.
- Counter updates become visible the cycle after the triggering edge.
- A retire in cycle N releases a dependent stall in cycle N+1, not N. The register file write lands at the same edge, so the read in N+1 sees the new value.
- busy_mask reflects counts registered at the last edge.
- An issued instruction reading its own rd (e.g., rs1 == rd) is not stalled by its own increment.
- rst mid-operation clears all state at the next edge regardless of other inputs.

## Test plan
- Reset, then check busy_mask = 0, error = 0, and stall = 0 with issue_valid = 1, rs1 = 5, rs1_used = 1.
- Issue rd = 5 in cycle 0 (issue_fire = 1). Cycle 1: rs1 = 5 gives stall = 1 and busy_mask[5] = 1. Retire rd = 5 in cycle 3: stall stays 1 in cycle 3 and drops to 0 in cycle 4.
- Issue rd = 7 three times (CNT_WIDTH = 2). The fourth issue to rd = 7 gives stall = 1 with no source hazard. Retire rd = 7 once, and the next cycle the issue fires with count = 3.
- Count[9] = 1. Issue rd = 9 and retire rd = 9 in the same cycle, so count[9] stays 1. Then retire rd = 9 and cancel rd = 9 in the same cycle with count[9] = 1: count goes to 0 and error = 1.
- Issue rd = 0, rs1 = 0, rs2 = 0: stall = 0 and busy_mask = 0. Retire rd = 0 leaves error = 0.
- Registers 3, 4 and 6 are busy. Assert flush_all together with an issue to rd = 8: next cycle busy_mask = 0, error is unchanged, and rs1 = 3 gives stall = 0.
